// File: rtl/vec_checker_pkg.sv
// Shared types for the vec_checker self-check engine: FSM state encoding and
// the field layout of a {stimulus, expected} vector word.
package vec_checker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // A vector word is viewed as logic [1:0][WIDTH-1:0]; these select the halves.
    localparam int STIM_FIELD = 1;
    localparam int EXP_FIELD  = 0;

    localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/vec_checker_mem.sv
// Vector store for vec_checker: DEPTH x 2*WIDTH register file,
// synchronous write, asynchronous read. Contents are deliberately not reset.
module vec_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [2*WIDTH-1:0]   wdata,
    input  logic [AW-1:0]        raddr,
    output logic [2*WIDTH-1:0]   rdata
);

    logic [2*WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/vec_checker.sv
// On-board self-check engine: applies stored stimuli to a combinational DUT,
// waits SETTLE cycles, compares its response and tallies pass/fail.
// Optional build macro: VEC_CHECKER_STOP_ON_FAIL_EN ends the run at the first mismatch.
module vec_checker
    import vec_checker_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int AW     = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vec_we,
    input  logic [AW-1:0]        vec_addr,
    input  logic [2*WIDTH-1:0]   vec_wdata,
    input  logic                 start,
    output logic [WIDTH-1:0]     stim,
    input  logic [WIDTH-1:0]     resp,
    output logic                 busy,
    output logic                 done,
    output logic [AW:0]          pass_cnt,
    output logic [AW:0]          fail_cnt,
    output logic [AW-1:0]        first_fail
);

    localparam logic [AW-1:0]           LAST_IDX    = AW'(DEPTH - 1);
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE - 1);

    state_t                    state_reg;
    logic [AW-1:0]             idx_reg;
    logic [SETTLE_CNT_W-1:0]   settle_reg;
    logic [WIDTH-1:0]          stim_reg;
    logic                      busy_reg;
    logic                      done_reg;
    logic [AW:0]               pass_reg;
    logic [AW:0]               fail_reg;
    logic [AW-1:0]             first_fail_reg;

    logic                      mem_we;
    logic [2*WIDTH-1:0]        rd_data;
    logic [1:0][WIDTH-1:0]     rd_word;
    logic                      match;
    logic                      last_vec;
    logic                      stop_next;

    // The memory only accepts writes while no run is using it.
    assign mem_we = vec_we && (state_reg == ST_IDLE || state_reg == ST_DONE);

    vec_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (vec_addr),
        .wdata (vec_wdata),
        .raddr (idx_reg),
        .rdata (rd_data)
    );

    assign rd_word  = rd_data;
    assign match    = (resp == rd_word[EXP_FIELD]);
    assign last_vec = (idx_reg == LAST_IDX);

`ifdef VEC_CHECKER_STOP_ON_FAIL_EN
    assign stop_next = last_vec || !match;
`else
    assign stop_next = last_vec;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            settle_reg     <= '0;
            stim_reg       <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            pass_reg       <= '0;
            fail_reg       <= '0;
            first_fail_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        pass_reg       <= '0;
                        fail_reg       <= '0;
                        first_fail_reg <= '0;
                        idx_reg        <= '0;
                        done_reg       <= 1'b0;
                        busy_reg       <= 1'b1;
                        state_reg      <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    stim_reg   <= rd_word[STIM_FIELD];
                    settle_reg <= SETTLE_LOAD;
                    state_reg  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (settle_reg == '0) begin
                        state_reg <= ST_CHECK;
                    end else begin
                        settle_reg <= settle_reg - 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (match) begin
                        pass_reg <= pass_reg + 1'b1;
                    end else begin
                        fail_reg <= fail_reg + 1'b1;
                        if (fail_reg == '0) begin
                            first_fail_reg <= idx_reg;
                        end
                    end
                    if (stop_next) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        idx_reg   <= idx_reg + 1'b1;
                        state_reg <= ST_DRIVE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign stim       = stim_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign pass_cnt   = pass_reg;
    assign fail_cnt   = fail_reg;
    assign first_fail = first_fail_reg;

endmodule

// File: tb/tb_vec_checker.sv
// Directed bench for vec_checker: Inc16 vector tables plus reset, ignored-write
// and settle-window sequences, with a second instance at SETTLE=3.
module tb_vec_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        vec_we;
    logic [1:0]  vec_addr;
    logic [31:0] vec_wdata;
    logic        start;
    logic [15:0] stim, resp;
    logic        busy, done;
    logic [2:0]  pass_cnt, fail_cnt;
    logic [1:0]  first_fail;

    logic [15:0] stim3, resp3;
    logic        busy3, done3;
    logic [2:0]  pass3, fail3;
    logic [1:0]  ff3;

    logic        use_lag;
    logic [15:0] lag_a, lag_b, lag3_a, lag3_b;

    int nvec = 0;
    int nmis = 0;
    int ncyc;

    always #5 clk = ~clk;

    // Behavioural Inc16, optionally through a two-cycle pipeline.
    always @(posedge clk) begin
        lag_a  <= stim + 16'd1;
        lag_b  <= lag_a;
        lag3_a <= stim3 + 16'd1;
        lag3_b <= lag3_a;
    end
    assign resp  = use_lag ? lag_b : stim + 16'd1;
    assign resp3 = lag3_b;

    vec_checker #(.WIDTH(16), .DEPTH(4), .AW(2), .SETTLE(1)) dut (
        .clk(clk), .reset(reset), .vec_we(vec_we), .vec_addr(vec_addr),
        .vec_wdata(vec_wdata), .start(start), .stim(stim), .resp(resp),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail(first_fail)
    );

    vec_checker #(.WIDTH(16), .DEPTH(4), .AW(2), .SETTLE(3)) dut3 (
        .clk(clk), .reset(reset), .vec_we(vec_we), .vec_addr(vec_addr),
        .vec_wdata(vec_wdata), .start(start), .stim(stim3), .resp(resp3),
        .busy(busy3), .done(done3), .pass_cnt(pass3), .fail_cnt(fail3),
        .first_fail(ff3)
    );

    typedef struct {
        logic [15:0] st [4];
        logic [15:0] ex [4];
        int          pass_e;
        int          fail_e;
        int          ff_e;
        int          cyc_e;
    } vec_t;

    vec_t        tbl [5];
    logic [15:0] inc_st [4] = '{16'h0000, 16'hFFFF, 16'h0005, 16'hFFFB};
    logic [15:0] inc_ex [4] = '{16'h0001, 16'h0000, 16'h0006, 16'hFFFC};
    logic [15:0] alt_st [4] = '{16'h1234, 16'h7FFF, 16'h8000, 16'h00FF};
    logic [15:0] alt_ex [4] = '{16'h1235, 16'h8000, 16'h8001, 16'h0100};

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic write_entry(input int addr, input logic [15:0] st, input logic [15:0] ex);
        @(negedge clk);
        vec_we    = 1'b1;
        vec_addr  = 2'(addr);
        vec_wdata = {st, ex};
        @(negedge clk);
        vec_we    = 1'b0;
    endtask

    task automatic load_row(input vec_t r);
        for (int i = 0; i < 4; i++) write_entry(i, r.st[i], r.ex[i]);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ncyc = 0;
    endtask

    task automatic wait_done();
        while (!done && ncyc < 100) begin
            @(negedge clk);
            ncyc++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic check_result(input string tag, input int pe, input int fe, input int ffe, input int ce);
        chk({tag, "_cycles"}, ncyc, ce);
        chk({tag, "_pass"}, int'(pass_cnt), pe);
        chk({tag, "_fail"}, int'(fail_cnt), fe);
        chk({tag, "_busy"}, int'(busy), 0);
        if (fe != 0) chk({tag, "_first_fail"}, int'(first_fail), ffe);
        $display("%s: cycles=%0d pass=%0d fail=%0d first_fail=%0d", tag, ncyc, pass_cnt, fail_cnt, first_fail);
    endtask

    initial begin
        reset = 1'b1; vec_we = 1'b0; vec_addr = '0; vec_wdata = '0;
        start = 1'b0; use_lag = 1'b0;

        for (int i = 0; i < 5; i++) begin
            tbl[i].st = inc_st; tbl[i].ex = inc_ex;
            tbl[i].pass_e = 4; tbl[i].fail_e = 0; tbl[i].ff_e = 0; tbl[i].cyc_e = 12;
        end
        tbl[1].ex[2] = 16'h0007;
        for (int i = 0; i < 4; i++) tbl[2].ex[i] = inc_ex[i] + 16'd1;
        tbl[3].st = alt_st; tbl[3].ex = alt_ex;
        tbl[4].st = alt_st; tbl[4].ex = alt_ex; tbl[4].ex[3] = 16'h0000;
`ifdef VEC_CHECKER_STOP_ON_FAIL_EN
        tbl[1].pass_e = 2; tbl[1].fail_e = 1; tbl[1].ff_e = 2; tbl[1].cyc_e = 9;
        tbl[2].pass_e = 0; tbl[2].fail_e = 1; tbl[2].ff_e = 0; tbl[2].cyc_e = 3;
`else
        tbl[1].pass_e = 3; tbl[1].fail_e = 1; tbl[1].ff_e = 2;
        tbl[2].pass_e = 0; tbl[2].fail_e = 4; tbl[2].ff_e = 0;
`endif
        tbl[4].pass_e = 3; tbl[4].fail_e = 1; tbl[4].ff_e = 3;

        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pass", int'(pass_cnt), 0);
        chk("reset_fail", int'(fail_cnt), 0);
        chk("reset_stim", int'(stim), 0);
        $display("reset: busy=%0d done=%0d stim=%0h", busy, done, stim);
        reset = 1'b0;

        for (int r = 0; r < 5; r++) begin
            load_row(tbl[r]);
            start_pulse();
            chk($sformatf("row%0d_busy_at_start", r), int'(busy), 1);
            chk($sformatf("row%0d_done_cleared", r), int'(done), 0);
            wait_done();
            check_result($sformatf("row%0d", r), tbl[r].pass_e, tbl[r].fail_e, tbl[r].ff_e, tbl[r].cyc_e);
        end

        // Write and start in the same IDLE/DONE cycle: the run sees the new word.
        load_row(tbl[0]);
        @(negedge clk);
        vec_we = 1'b1; vec_addr = 2'd2; vec_wdata = {16'h0005, 16'h0007}; start = 1'b1;
        @(negedge clk);
        vec_we = 1'b0; start = 1'b0; ncyc = 0;
        wait_done();
        chk("we_start_fail", int'(fail_cnt), 1);
        chk("we_start_first_fail", int'(first_fail), 2);
        $display("we_start: pass=%0d fail=%0d first_fail=%0d", pass_cnt, fail_cnt, first_fail);

        // Reset during WAIT of vector 1, then restart from preserved memory.
        load_row(tbl[0]);
        start_pulse();
        repeat (4) begin @(negedge clk); ncyc++; end
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done", int'(done), 0);
        chk("midreset_pass", int'(pass_cnt), 0);
        chk("midreset_fail", int'(fail_cnt), 0);
        chk("midreset_stim", int'(stim), 0);
        $display("midreset: busy=%0d done=%0d pass=%0d stim=%0h", busy, done, pass_cnt, stim);
        reset = 1'b0;
        start_pulse();
        wait_done();
        check_result("after_reset", 4, 0, 0, 12);

        // start and vec_we during a run are both ignored.
        start_pulse();
        repeat (4) begin @(negedge clk); ncyc++; end
        start = 1'b1; vec_we = 1'b1; vec_addr = 2'd0; vec_wdata = {16'h1234, 16'h9999};
        @(negedge clk); ncyc++;
        start = 1'b0; vec_we = 1'b0;
        wait_done();
        check_result("busy_ignore", 4, 0, 0, 12);
        start_pulse();
        wait_done();
        check_result("readback", 4, 0, 0, 12);

        // Two-cycle-lag DUT: SETTLE=3 instance passes, SETTLE=1 instance does not.
        for (int k = 0; k < 100 && busy3; k++) @(negedge clk);
        chk("settle3_idle", int'(busy3), 0);
        use_lag = 1'b1;
        load_row(tbl[0]);
        start_pulse();
        wait_done();
        chk("lag_settle1_has_fail", int'(fail_cnt != 0), 1);
        $display("lag settle1: pass=%0d fail=%0d", pass_cnt, fail_cnt);
        for (int k = 0; k < 100 && !done3; k++) @(negedge clk);
        chk("lag_settle3_done", int'(done3), 1);
        chk("lag_settle3_pass", int'(pass3), 4);
        chk("lag_settle3_fail", int'(fail3), 0);
        $display("lag settle3: pass=%0d fail=%0d", pass3, fail3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
